// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and framing constants for the imem loader
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CHK, DONE, ERR} state_t;
  localparam int HDR_BYTES = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_loader_word_asm.sv
// imem_loader_word_asm: shifts bytes LSB-first into a 32-bit word and pulses done one cycle after the 4th byte
module imem_loader_word_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        last,
  output logic        done
);
  logic [$clog2(WORD_BYTES)-1:0] idx;
  assign last = idx == ($clog2(WORD_BYTES))'(WORD_BYTES - 1);
  // byte shift register, byte index and registered word-complete strobe
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx  <= '0;
      word <= '0;
      done <= 1'b0;
    end else begin
      done <= en && last;
      if (en) begin
        word <= {data, word[31:8]};
        idx  <= idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader into imem; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W      = 11,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_wr_en,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic        o_cpu_rst
);
  state_t state, nxt, hdr_nxt, data_nxt, chk_nxt;
  logic [8*HDR_BYTES-1:0] n, hdr;
  logic [ADDR_W:0] wcnt, widx;
  logic [31:0] idle, word;
  logic xfer, start_ok, tmo, asm_en, last, wdone;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif
  assign o_busy     = state inside {HDR0, HDR1, DATA, CHK};
  assign o_rx_ready = o_busy;
  assign o_done     = state == DONE;
  assign o_error    = state == ERR;
  assign o_cpu_rst  = !(state inside {IDLE, DONE});
  assign xfer       = i_rx_valid && o_rx_ready;
  assign start_ok   = i_start && state inside {IDLE, DONE, ERR};
  assign tmo        = o_busy && !xfer && idle == 32'(TIMEOUT_CYC - 1);
  assign asm_en     = xfer && state == DATA;
  assign hdr        = {i_rx_data, n[8*HDR_BYTES-1:8]};
  assign o_wr_en    = wdone;
  assign o_wr_addr  = wdone ? BASE_ADDR + 32'({widx, 2'b00}) : 32'h0;
  assign o_wr_data  = wdone ? word : 32'h0;
  imem_loader_word_asm u_asm (
    .clk (clk),
    .rst (rst),
    .clr (start_ok || tmo),
    .en  (asm_en),
    .data(i_rx_data),
    .word(word),
    .last(last),
    .done(wdone)
  );
  // next-state selection: start, then timeout, then byte-driven advance
  always_comb begin
    hdr_nxt  = hdr == '0 ? DONE : 32'(hdr) > (32'd1 << ADDR_W) ? ERR : DATA;
    data_nxt = (last && 32'(wcnt) + 32'd1 == 32'(n)) ? FIN : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_nxt  = i_rx_data == sum ? DONE : ERR;
`else
    chk_nxt  = ERR;
`endif
    nxt = start_ok ? HDR0 : tmo ? ERR : !xfer ? state :
          state == HDR0 ? HDR1 : state == HDR1 ? hdr_nxt :
          state == DATA ? data_nxt : state == CHK ? chk_nxt : state;
  end
  // state, header count, word counters, idle timer and running checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n     <= '0;
      wcnt  <= '0;
      widx  <= '0;
      idle  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum   <= '0;
`endif
    end else begin
      state <= nxt;
      idle  <= (xfer || start_ok) ? 32'h0 : o_busy ? idle + 32'd1 : idle;
      if (start_ok) begin
        wcnt <= '0;
        widx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum  <= '0;
`endif
      end else begin
        if (xfer && state inside {HDR0, HDR1}) n <= hdr;
        if (asm_en && last) wcnt <= wcnt + 1'b1;
        if (wdone) widx <= widx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (asm_en) sum <= sum + i_rx_data;
`endif
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed-vector bench for imem_loader (BASE_ADDR 0x100, TIMEOUT_CYC 16)
module tb_imem_loader;
  logic clk = 0, rst = 1, i_start = 0, i_rx_valid = 0;
  logic [7:0] i_rx_data = 0;
  logic o_rx_ready, o_wr_en, o_busy, o_done, o_error, o_cpu_rst;
  logic [31:0] o_wr_addr, o_wr_data;
  int vecs = 0, errs = 0;
  logic [31:0] wa[$], wd[$];
  logic [7:0] fr[$];
  logic [31:0] exp_w[4] = '{32'h44332211, 32'h88776655, 32'h04030201, 32'hefbeadde};

  imem_loader #(.ADDR_W(11), .BASE_ADDR(32'h100), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_rx_ready(o_rx_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_cpu_rst(o_cpu_rst)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_wr_en) begin
    wa.push_back(o_wr_addr);
    wd.push_back(o_wr_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic gap(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    i_start = 1;
    gap(1);
    i_start = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    i_rx_valid = 1;
    i_rx_data  = b;
    while (!o_rx_ready && t < 50) begin
      gap(1);
      t++;
    end
    if (t >= 50) chk("rdy_timeout", {31'h0, o_rx_ready}, 1);
    gap(1);
    i_rx_valid = 0;
  endtask

  task automatic send_fr(input bit rnd, input int poke);
    int n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] s = 0;
`endif
    n = int'({fr[1], fr[0]});
    for (int i = 0; i < fr.size(); i++) begin
      if (i == poke) pulse();
      send(fr[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (i >= 2) s += fr[i];
`endif
      if (rnd) gap($urandom_range(0, 3));
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (n != 0 && n <= 2048) send(s);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    gap(3);
    rst = 0;
    chk("rst_flags", {26'h0, o_rx_ready, o_wr_en, o_busy, o_done, o_error, o_cpu_rst}, 0);
    chk("rst_addr", o_wr_addr, 0);
    chk("rst_data", o_wr_data, 0);

    pulse();
    chk("t1_busy_rst", {30'h0, o_busy, o_cpu_rst}, 2'b11);
    fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_fr(0, -1);
    gap(2);
    chk("t1_nwr", wa.size(), 2);
    chk("t1_a0", wa[0], 32'h100);
    chk("t1_d0", wd[0], 32'h00000013);
    chk("t1_a1", wa[1], 32'h104);
    chk("t1_d1", wd[1], 32'h00100093);
    chk("t1_flags", {29'h0, o_done, o_error, o_cpu_rst}, 3'b100);
    i_rx_valid = 1;
    #1 chk("t1_done_rdy", {31'h0, o_rx_ready}, 0);
    i_rx_valid = 0;

    wa.delete(); wd.delete();
    pulse();
    chk("t2_done_clr", {31'h0, o_done}, 0);
    fr = '{8'h00, 8'h00};
    send_fr(0, -1);
    chk("t2_n0_done", {30'h0, o_done, o_cpu_rst}, 2'b10);
    pulse();
    fr = '{8'h01, 8'h08};
    send_fr(0, -1);
    gap(1);
    chk("t2_big_err", {29'h0, o_error, o_cpu_rst, o_busy}, 3'b110);
    chk("t2_nwr", wa.size(), 0);

    pulse();
    fr = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
           8'h01, 8'h02, 8'h03, 8'h04, 8'hde, 8'had, 8'hbe, 8'hef};
    send_fr(1, 5);
    gap(2);
    chk("t3_nwr", wa.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_a%0d", k), wa[k], 32'h100 + 32'(4 * k));
      chk($sformatf("t3_d%0d", k), wd[k], exp_w[k]);
    end
    chk("t3_done", {31'h0, o_done}, 1);

    wa.delete(); wd.delete();
    pulse();
    fr = '{8'h02, 8'h00, 8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'hb1, 8'hb2};
    foreach (fr[i]) send(fr[i]);
    gap(15);
    chk("t4_pre_tmo", {30'h0, o_error, o_busy}, 2'b01);
    gap(1);
    chk("t4_tmo_err", {30'h0, o_error, o_cpu_rst}, 2'b11);
    gap(2);
    chk("t4_nwr", wa.size(), 1);
    chk("t4_a0", wa[0], 32'h100);
    chk("t4_d0", wd[0], 32'ha4a3a2a1);

    wa.delete(); wd.delete();
    pulse();
    fr = '{8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    foreach (fr[i]) send(fr[i]);
    gap(1);
    rst = 1;
    gap(1);
    rst = 0;
    chk("t5_flags", {26'h0, o_rx_ready, o_wr_en, o_busy, o_done, o_error, o_cpu_rst}, 0);
    chk("t5_addr", o_wr_addr, 0);
    i_rx_valid = 1;
    i_rx_data  = 8'h03;
    gap(3);
    chk("t5_rdy", {31'h0, o_rx_ready}, 0);
    i_rx_valid = 0;
    chk("t5_nwr", wa.size(), 2);
    wa.delete(); wd.delete();
    pulse();
    fr = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_fr(0, -1);
    gap(2);
    chk("t5_re_nwr", wa.size(), 1);
    chk("t5_re_a0", wa[0], 32'h100);
    chk("t5_re_d0", wd[0], 32'h12345678);
    chk("t5_re_done", {31'h0, o_done}, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    wa.delete(); wd.delete();
    pulse();
    fr = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_fr(0, -1);
    gap(2);
    chk("t6_ok_done", {30'h0, o_done, o_error}, 2'b10);
    chk("t6_ok_d0", wd[0], 32'h44332211);
    wa.delete(); wd.delete();
    pulse();
    foreach (fr[i]) send(fr[i]);
    chk("t6_chk_wait", {31'h0, o_busy}, 1);
    send(8'hab);
    gap(1);
    chk("t6_bad_err", {30'h0, o_error, o_cpu_rst}, 2'b11);
    chk("t6_bad_nwr", wa.size(), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
